// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: read-cache line handshake (rd_*) and fetch-queue push port (fq_*).
// The master side is the fetch unit; the slave side is the cache plus fetch queue.
interface fetch_if #(
    parameter int LINE_BYTES = 64,
    parameter int ADDR_W     = 64
);
    logic                     rd_reqcyc;
    logic [ADDR_W-1:0]        rd_addr;
    logic                     rd_respcyc;
    logic [0:LINE_BYTES*8-1]  rd_data;
    logic                     fq_enq;
    int                       fq_in_cnt;
    logic [0:LINE_BYTES*8-1]  fq_in_data;
    logic                     fq_flush;
    int                       fq_empty_cnt;

    modport master (
        output rd_reqcyc, rd_addr, fq_enq, fq_in_cnt, fq_in_data, fq_flush,
        input  rd_respcyc, rd_data, fq_empty_cnt
    );

    modport slave (
        input  rd_reqcyc, rd_addr, fq_enq, fq_in_cnt, fq_in_data, fq_flush,
        output rd_respcyc, rd_data, fq_empty_cnt
    );
endinterface

// File: rtl/fetch_unit.sv
// Front-end fetch stage: requests cache lines at the fetch address, aligns each returned line
// to the fetch offset and pushes it into the fetch queue; redirects flush and drop in-flight data.
module fetch_unit #(
    parameter int LINE_BYTES  = 64,
    parameter int ADDR_W      = 64,
    parameter int REFILL_BITS = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] entry,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [31:0]       stat_lines,
    fetch_if.master           bus
);
    localparam int OFS_W  = $clog2(LINE_BYTES);
    localparam int LINE_W = LINE_BYTES * 8;
    localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(LINE_BYTES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;
    logic [31:0]       stat_lines_q, stat_lines_d;
    logic              reqcyc_q;

    logic [ADDR_W-1:0] line_addr;
    logic [OFS_W-1:0]  offset;
    logic              room, room_b2b, take_line;

    assign line_addr = fetch_addr_q & ~OFS_MASK;
    assign offset    = fetch_addr_q[OFS_W-1:0];
    assign room      = bus.fq_empty_cnt >= REFILL_BITS;
    // Chaining needs room for the line being pushed now plus a full refill after it.
    assign room_b2b  = bus.fq_empty_cnt >= REFILL_BITS + LINE_W;
    assign take_line = !reset && (state_q == ST_BUSY) && bus.rd_respcyc && !redirect_valid;

    assign bus.rd_reqcyc  = reqcyc_q;
    assign bus.rd_addr    = (state_q == ST_DROP) ? drop_addr_q : line_addr;
    assign bus.fq_enq     = take_line;
    assign bus.fq_flush   = !reset && redirect_valid;
    assign bus.fq_in_cnt  = (LINE_BYTES - int'(offset)) * 8;
    assign bus.fq_in_data = bus.rd_data << {offset, 3'b000};
    assign stat_lines     = stat_lines_q;

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        drop_addr_d  = drop_addr_q;
        stat_lines_d = stat_lines_q;
        if (redirect_valid) begin
            fetch_addr_d = redirect_addr;
            if (state_q != ST_IDLE) begin
                state_d = bus.rd_respcyc ? ST_IDLE : ST_DROP;
            end
            // The outstanding request keeps its address even though fetch_addr moves on.
            if (state_q == ST_BUSY && !bus.rd_respcyc) begin
                drop_addr_d = line_addr;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (room) begin
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.rd_respcyc) begin
                        fetch_addr_d = line_addr + ADDR_W'(LINE_BYTES);
                        stat_lines_d = stat_lines_q + 32'd1;
                        state_d      = room_b2b ? ST_BUSY : ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (bus.rd_respcyc) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            reqcyc_q     <= 1'b0;
            fetch_addr_q <= entry;
            stat_lines_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            reqcyc_q     <= (state_d != ST_IDLE);
            fetch_addr_q <= fetch_addr_d;
            stat_lines_q <= stat_lines_d;
        end
    end

    always_ff @(posedge clk) begin
        drop_addr_q <= drop_addr_d;
    end
endmodule
